// File: rtl/hbridge_pkg.sv
// Shared types and gate encodings for the speaker H-bridge driver.
// Gate vectors are packed as {hiA, loA, hiB, loB}.
package hbridge_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DEAD  = 3'd1,
        ST_FWD   = 3'd2,
        ST_REV   = 3'd3,
        ST_BRAKE = 3'd4
    } bridge_state_t;

    localparam logic [3:0] GATES_OFF   = 4'b0000;
    localparam logic [3:0] GATES_FWD   = 4'b1001;
    localparam logic [3:0] GATES_REV   = 4'b0110;
    localparam logic [3:0] GATES_BRAKE = 4'b0101;

    function automatic logic [3:0] gates_of(input bridge_state_t st);
        case (st)
            ST_FWD:   return GATES_FWD;
            ST_REV:   return GATES_REV;
            ST_BRAKE: return GATES_BRAKE;
            default:  return GATES_OFF;
        endcase
    endfunction

endpackage

// File: rtl/hbridge_driver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Kept generic so other async inputs can share it.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/hbridge_driver.sv
// Full H-bridge gate driver: sign + PWM carrier to four gate drives,
// with enforced all-off dead time and a latched over-current fault.
//
//   state | meaning
//   OFF   | bridge disabled or faulted, all gates off
//   DEAD  | all gates off while the dead-time counter runs out
//   FWD   | hiA + loB on
//   REV   | hiB + loA on
//   BRAKE | loA + loB on, low-side freewheel
module hbridge_driver
    import hbridge_pkg::*;
#(
    parameter int DEADTIME = 8,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sign,
    input  logic waveOut,
    input  logic fault,
    input  logic clearFault,
    output logic hiA,
    output logic loA,
    output logic hiB,
    output logic loB,
    output logic faulted
);

    localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DEADTIME - 1);

    generate
        if (DEADTIME < 1 || DEADTIME > (1 << CNT_W) - 1) begin : g_bad_deadtime
            $error("hbridge_driver: DEADTIME must lie in 1..2^CNT_W-1");
        end
    endgenerate

    bridge_state_t    r_state;
    bridge_state_t    w_next;
    bridge_state_t    w_target;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_gates;
    logic             r_faulted;
    logic             w_fsync2;

    sync_2ff u_fault_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (fault),
        .o_q     (w_fsync2)
    );

    always_comb begin
        w_target = ST_OFF;
        if (!(r_faulted || w_fsync2 || !enable)) begin
            if (waveOut) w_target = sign ? ST_REV : ST_FWD;
            else         w_target = ST_BRAKE;
        end
    end

    // Turn-off bypasses the dead time; every turn-on goes through DEAD.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (w_target == ST_OFF) begin
            w_next     = ST_OFF;
            w_cnt_next = '0;
        end else if (r_state == ST_DEAD) begin
            if (r_cnt == '0) w_next = w_target;
            else             w_cnt_next = r_cnt - CNT_W'(1);
        end else if (r_state != w_target) begin
            w_next     = ST_DEAD;
            w_cnt_next = DT_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_gates <= GATES_OFF;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_gates <= gates_of(w_next);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_faulted <= 1'b0;
        else if (w_fsync2) r_faulted <= 1'b1;
        else if (clearFault) r_faulted <= 1'b0;
    end

    assign {hiA, loA, hiB, loB} = r_gates;
    assign faulted = r_faulted;

`ifndef SYNTHESIS
    a_no_shoot_a: assert property (@(posedge clk) disable iff (!reset) !(hiA && loA))
        else $error("hbridge_driver: shoot-through on leg A");
    a_no_shoot_b: assert property (@(posedge clk) disable iff (!reset) !(hiB && loB))
        else $error("hbridge_driver: shoot-through on leg B");
`endif

endmodule

// File: tb/tb_hbridge_driver.sv
// Directed and random-stress bench for hbridge_driver with DEADTIME = 8.
module tb_hbridge_driver;
    import hbridge_pkg::*;

    localparam int DT = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic sign = 1'b0;
    logic waveOut = 1'b0;
    logic fault = 1'b0;
    logic clearFault = 1'b0;
    logic hiA, loA, hiB, loB, faulted;
    logic [3:0] gates;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hbridge_driver #(.DEADTIME(DT), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sign       (sign),
        .waveOut    (waveOut),
        .fault      (fault),
        .clearFault (clearFault),
        .hiA        (hiA),
        .loA        (loA),
        .hiB        (hiB),
        .loB        (loB),
        .faulted    (faulted)
    );

    assign gates = {hiA, loA, hiB, loB};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_dead_then(input string tag, input logic [3:0] cfg);
        for (int i = 0; i < DT; i++) begin
            step();
            chk({tag, "_dead"}, 32'(gates), 32'(GATES_OFF));
        end
        step();
        chk({tag, "_cfg"}, 32'(gates), 32'(cfg));
    endtask

    initial begin
        int off_run;
        int rst_hold;
        logic [3:0] prev;

        // reset held with a live target
        enable  = 1'b1;
        waveOut = 1'b1;
        @(negedge clk);
        step(); step(); step();
        chk("rst_gates", 32'(gates), 32'(GATES_OFF));
        chk("rst_faulted", 32'(faulted), 32'd0);
        reset = 1'b1;
        expect_dead_then("rst_fwd", GATES_FWD);
        step();
        chk("fwd_hold", 32'(gates), 32'(GATES_FWD));

        // carrier edges
        waveOut = 1'b0;
        expect_dead_then("fall_brake", GATES_BRAKE);
        waveOut = 1'b1;
        expect_dead_then("rise_fwd", GATES_FWD);
        waveOut = 1'b0;
        expect_dead_then("fall_brake2", GATES_BRAKE);

        // 3-cycle pulse from BRAKE is swallowed by the dead time
        waveOut = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("short_on", 32'(gates), 32'(GATES_OFF));
        end
        waveOut = 1'b0;
        for (int i = 0; i < DT - 3; i++) begin
            step();
            chk("short_dead", 32'(gates), 32'(GATES_OFF));
        end
        step();
        chk("short_brake", 32'(gates), 32'(GATES_BRAKE));

        // sign flip in FWD
        waveOut = 1'b1;
        expect_dead_then("pre_flip", GATES_FWD);
        sign = 1'b1;
        expect_dead_then("flip_rev", GATES_REV);
        sign = 1'b0;
        expect_dead_then("flip_fwd", GATES_FWD);

        // fault mid-FWD, clear ignored while fault still asserted
        fault = 1'b1;
        step(); step(); step();
        chk("flt_gates", 32'(gates), 32'(GATES_OFF));
        chk("flt_latched", 32'(faulted), 32'd1);
        clearFault = 1'b1;
        step();
        clearFault = 1'b0;
        chk("flt_clr_ignored", 32'(faulted), 32'd1);
        fault = 1'b0;
        step(); step();
        chk("flt_still_latched", 32'(faulted), 32'd1);
        chk("flt_still_off", 32'(gates), 32'(GATES_OFF));
        clearFault = 1'b1;
        step();
        clearFault = 1'b0;
        chk("flt_cleared", 32'(faulted), 32'd0);
        chk("flt_clr_off", 32'(gates), 32'(GATES_OFF));
        expect_dead_then("flt_resume", GATES_FWD);

        // enable drop is immediate, re-enable goes through DEAD
        enable = 1'b0;
        step();
        chk("en_off", 32'(gates), 32'(GATES_OFF));
        enable = 1'b1;
        expect_dead_then("en_on", GATES_FWD);

        // reset clears a latched fault
        fault = 1'b1;
        step(); step(); step();
        chk("flt2_latched", 32'(faulted), 32'd1);
        fault = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_clr_fault", 32'(faulted), 32'd0);
        chk("rst_clr_gates", 32'(gates), 32'(GATES_OFF));
        @(negedge clk);
        reset = 1'b1;
        expect_dead_then("post_rst", GATES_FWD);

        // reset in the middle of DEAD restarts the full dead time
        waveOut = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        #1;
        chk("middead_rst", 32'(gates), 32'(GATES_OFF));
        @(negedge clk);
        reset = 1'b1;
        expect_dead_then("middead_after", GATES_BRAKE);

        // random stress with async reset pulses
        off_run  = 0;
        rst_hold = 0;
        prev     = gates;
        for (int c = 0; c < 10000; c++) begin
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                reset    = 1'b0;
                rst_hold = $urandom_range(1, 3);
            end
            enable = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 19) == 0) sign = ~sign;
            if ($urandom_range(0, 5) == 0) waveOut = ~waveOut;
            step();
            chk("stress_shoot", {30'd0, hiA & loA, hiB & loB}, 32'd0);
            if ((gates & ~prev) != 4'b0000)
                chk("stress_deadtime", (off_run >= DT) ? 32'(DT) : 32'(off_run), 32'(DT));
            off_run = (gates == 4'b0000) ? off_run + 1 : 0;
            prev    = gates;
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hbridge_driver.md
# hbridge_driver

Converts the note-signal sign and the 40 MHz PWM carrier into the four gate drives of a full H-bridge for the speaker output stage. Sits directly downstream of the wave/PWM generators in `top`, replacing the raw `signOut`/`carrierOut` debug outputs. Guarantees no shoot-through: every change of bridge configuration passes through a programmable all-off dead time. Also latches an external over-current fault and holds the bridge off until it is cleared.

## Interface
- `DEADTIME`, default 8: all-off cycles inserted between bridge configurations (200 ns at 40 MHz); legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: dead-time counter width.

- `clk`  in  1  system clock, 40 MHz.
- `reset`  in  1  asynchronous, active-low (0 = in reset).
- `enable`  in  1  bridge enable; synchronous to `clk`.
- `sign`  in  1  note sign (0 = forward, 1 = reverse); synchronous to `clk`.
- `waveOut`  in  1  PWM carrier; synchronous to `clk`.
- `fault`  in  1  over-current comparator, asynchronous, active-high.
- `clearFault`  in  1  single-cycle request to clear the fault latch.
- `hiA`, `loA`, `hiB`, `loB`  out  1 each  registered gate drives.
- `faulted`  out  1  fault latch state.

## Operation
- States: OFF, DEAD, FWD, REV, BRAKE.
- Gate encoding:
  - OFF and DEAD drive all gates 0.
  - FWD drives hiA=1, loB=1.
  - REV drives hiB=1, loA=1.
  - BRAKE drives loA=1, loB=1 (low-side freewheel).
- Gates are decoded from the next state and registered, so gates always equal the encoding of the current state.
- Target configuration, evaluated every cycle:
  - OFF if `faulted`, the synchronized fault (`fSync2`) or `!enable`.
  - Otherwise (`sign` ? REV : FWD) when `waveOut` is 1.
  - Otherwise BRAKE.
- Transitions:
  - Target is OFF: go to OFF from any state at the next edge. Turn-off is never delayed.
  - Target equals the current state: stay.
  - Current state is OFF/FWD/REV/BRAKE and target differs: go to DEAD and load `cnt = DEADTIME-1`.
  - In DEAD with `cnt != 0`: decrement `cnt`.
  - In DEAD with `cnt == 0`: go to the target as sampled on that cycle, even if the target changed or returned to its old value during DEAD.
- Short PWM pulses: a pulse that ends during DEAD is dropped. Example: DEAD leads directly to BRAKE and the high side never turns on.
- Fault handling:
  - `fault` passes through a 2-FF synchronizer (`fSync1`, `fSync2`).
  - `faulted` sets when `fSync2` = 1.
  - `faulted` clears on `clearFault` = 1 only when `fSync2` = 0.
  - Setting dominates clearing on the same cycle.
- Reset (asserted at any time, including mid-DEAD): all gates 0, state OFF, `cnt` 0, `faulted` 0, synchronizers 0, asynchronously.
- After reset deasserts, the first non-OFF configuration is entered via DEAD.

## Timing
- Configuration-change latency: a target change sampled at edge n puts gates at all-off after edge n+1. The new configuration is driven after edge n+1+DEADTIME.
- Turn-off latency:
  - `enable` falling: gates 0 after the next edge.
  - `fault` rising: gates 0 and `faulted` = 1 by the 3rd rising edge.
- Invariants that must hold every cycle:
  - Never (`hiA` & `loA`) and never (`hiB` & `loB`).
  - Any gate rising from 0 is preceded by at least DEADTIME consecutive all-off cycles.
- `DEADTIME` = 0 is illegal; reject it with an elaboration-time assertion.

## Structure
- `hbridge_pkg`:
  - State typedef `bridge_state_t`, a 3-bit enum.
  - Gate-vector constants `GATES_OFF`, `GATES_FWD`, `GATES_REV`, `GATES_BRAKE` as 4-bit {hiA, loA, hiB, loB}.
- Sub-module `sync_2ff`: a 2-flop synchronizer with async active-low reset. It is reused later for `chipSelect`.
- `hbridge_driver` holds the state machine, dead-time counter, fault latch and gate register.
- Shoot-through assertions live in the RTL under `ifndef SYNTHESIS`.

## Test plan
- **Reset:** hold `reset` = 0 with `enable` = 1, `waveOut` = 1 -> all gates 0, `faulted` = 0. Release -> 8 all-off cycles, then `hiA` = `loB` = 1.
- **Carrier edge:** DEADTIME = 8, `enable` = 1, `sign` = 0, steady BRAKE, `waveOut` rises -> 8 all-off cycles, then `hiA` = `loB` = 1. `waveOut` falls -> 8 all-off cycles, then `loA` = `loB` = 1.
- **Short pulse:** `waveOut` high for 3 cycles from BRAKE -> DEAD for 8 cycles, then BRAKE. `hiA` is never 1.
- **Sign flip:** `sign` 0 -> 1 while `waveOut` = 1 in FWD -> 8 all-off cycles, then `hiB` = `loA` = 1.
- **Fault:** `fault` pulse mid-FWD -> gates 0 by the 3rd edge and `faulted` = 1. `clearFault` while `fault` is still high is ignored. After `fault` goes low, `clearFault` -> `faulted` = 0, then DEAD for 8 cycles, then the target configuration.
- **Random stress:** 10k cycles of random `enable`/`sign`/`waveOut` plus async `reset` pulses -> both no-shoot-through and dead-time invariants hold every cycle.
